// File: rtl/vga_timing_monitor_if.sv
// Timing-only VGA bundle (counts, syncs, blanks) shared between generator and consumers.
interface itf_vga_no_rgb;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;

    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk);
endinterface

// File: rtl/vga_timing_monitor.sv
// Passive checker for the itf_vga_no_rgb timing bundle: lock tracking, frame counting, sticky errors.
// Define VGA_MON_SYNC_CHECK_EN to also check hsync/hblnk/vsync/vblnk decode (err_flags[5:2]).
//
// state  | meaning
// SEARCH | no checks, waiting for an hcount=0/vcount=0 sample
// LOCKED | every sample checked against the expected sequence and decode
module vga_timing_monitor #(
    parameter int H_TOTAL      = 1056,
    parameter int H_ACTIVE     = 800,
    parameter int H_SYNC_START = 840,
    parameter int H_SYNC_LEN   = 128,
    parameter int V_TOTAL      = 628,
    parameter int V_ACTIVE     = 600,
    parameter int V_SYNC_START = 601,
    parameter int V_SYNC_LEN   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    itf_vga_no_rgb.in    vga_in,
    input  logic         clr_err,
    output logic         locked,
    output logic         frame_start,
    output logic         err_pulse,
    output logic [5:0]   err_flags,
    output logic [7:0]   err_count,
    output logic [15:0]  frame_count
);

    localparam logic [10:0] HT    = 11'(H_TOTAL);
    localparam logic [10:0] HT_M1 = 11'(H_TOTAL - 1);
    localparam logic [10:0] VT    = 11'(V_TOTAL);
    localparam logic [10:0] VT_M1 = 11'(V_TOTAL - 1);

    typedef enum logic {SEARCH, LOCKED} state_t;
    state_t state;

    logic        s1_valid;
    logic [10:0] h_s1, v_s1;
    logic        hs_s1, hb_s1, vs_s1, vb_s1;
    logic [10:0] h_prev, v_prev;

    logic [10:0] exp_h, exp_v;
    logic [5:0]  err_now;
    logic [5:0]  chk_err;
    logic        is_origin;

`ifdef VGA_MON_SYNC_CHECK_EN
    localparam logic [10:0] HA  = 11'(H_ACTIVE);
    localparam logic [10:0] HSS = 11'(H_SYNC_START);
    localparam logic [10:0] HSE = 11'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [10:0] VA  = 11'(V_ACTIVE);
    localparam logic [10:0] VSS = 11'(V_SYNC_START);
    localparam logic [10:0] VSE = 11'(V_SYNC_START + V_SYNC_LEN);
`else
    logic unused_sync;
    assign unused_sync = ^{hs_s1, hb_s1, vs_s1, vb_s1};
`endif

    // Expected counts are derived from the sample before the one being checked
    always_comb begin
        exp_h = (h_prev == HT_M1) ? 11'd0 : h_prev + 11'd1;
        exp_v = v_prev;
        if (h_prev == HT_M1)
            exp_v = (v_prev == VT_M1) ? 11'd0 : v_prev + 11'd1;

        err_now    = '0;
        err_now[0] = (h_s1 != exp_h) || (h_s1 >= HT);
        err_now[1] = (v_s1 != exp_v) || (v_s1 >= VT);
`ifdef VGA_MON_SYNC_CHECK_EN
        err_now[2] = hs_s1 != ((h_s1 >= HSS) && (h_s1 < HSE));
        err_now[3] = hb_s1 != (h_s1 >= HA);
        err_now[4] = vs_s1 != ((v_s1 >= VSS) && (v_s1 < VSE));
        err_now[5] = vb_s1 != (v_s1 >= VA);
`endif
        chk_err   = (s1_valid && state == LOCKED) ? err_now : 6'd0;
        is_origin = (h_s1 == 11'd0) && (v_s1 == 11'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= SEARCH;
            s1_valid    <= 1'b0;
            h_s1        <= '0;
            v_s1        <= '0;
            hs_s1       <= 1'b0;
            hb_s1       <= 1'b0;
            vs_s1       <= 1'b0;
            vb_s1       <= 1'b0;
            h_prev      <= '0;
            v_prev      <= '0;
            locked      <= 1'b0;
            frame_start <= 1'b0;
            err_pulse   <= 1'b0;
            err_flags   <= '0;
            err_count   <= '0;
            frame_count <= '0;
        end else begin
            s1_valid <= 1'b1;
            h_s1     <= vga_in.hcount;
            v_s1     <= vga_in.vcount;
            hs_s1    <= vga_in.hsync;
            hb_s1    <= vga_in.hblnk;
            vs_s1    <= vga_in.vsync;
            vb_s1    <= vga_in.vblnk;
            h_prev   <= h_s1;
            v_prev   <= v_s1;

            frame_start <= 1'b0;
            err_pulse   <= 1'b0;

            if (s1_valid) begin
                case (state)
                    SEARCH: begin
                        if (is_origin) begin
                            state       <= LOCKED;
                            locked      <= 1'b1;
                            frame_start <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                        end
                    end
                    LOCKED: begin
                        if (|err_now) begin
                            state     <= SEARCH;
                            locked    <= 1'b0;
                            err_pulse <= 1'b1;
                        end else if (is_origin) begin
                            frame_start <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end

            // A clear coinciding with a new error keeps only that error
            if (clr_err) begin
                err_flags <= chk_err;
                err_count <= (|chk_err) ? 8'd1 : 8'd0;
            end else if (|chk_err) begin
                err_flags <= err_flags | chk_err;
                if (err_count != 8'hFF)
                    err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor; uses a scaled-down raster so whole frames stay short.
module tb_vga_timing_monitor;

    localparam int HT  = 40;
    localparam int HA  = 30;
    localparam int HSS = 32;
    localparam int HSL = 4;
    localparam int VT  = 20;
    localparam int VA  = 15;
    localparam int VSS = 16;
    localparam int VSL = 2;

    logic        clk;
    logic        rst_n;
    logic        clr_err;
    logic        locked;
    logic        frame_start;
    logic        err_pulse;
    logic [5:0]  err_flags;
    logic [7:0]  err_count;
    logic [15:0] frame_count;

    itf_vga_no_rgb vga();

    vga_timing_monitor #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .vga_in(vga),
        .clr_err(clr_err),
        .locked(locked),
        .frame_start(frame_start),
        .err_pulse(err_pulse),
        .err_flags(err_flags),
        .err_count(err_count),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_fs = 0;
    int n_ep = 0;
    always @(negedge clk) begin
        if (frame_start) n_fs <= n_fs + 1;
        if (err_pulse)   n_ep <= n_ep + 1;
    end

    int n_chk  = 0;
    int n_pass = 0;
    int gh = 35;
    int gv = 19;
    int exp_fc = 0;
    int fs0, ep0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic drive_clean();
        vga.hcount = 11'(gh);
        vga.vcount = 11'(gv);
        vga.hsync  = (gh >= HSS) && (gh < HSS + HSL);
        vga.hblnk  = (gh >= HA);
        vga.vsync  = (gv >= VSS) && (gv < VSS + VSL);
        vga.vblnk  = (gv >= VA);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (gh == HT - 1) begin
            gh = 0;
            gv = (gv == VT - 1) ? 0 : gv + 1;
        end else begin
            gh = gh + 1;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive_clean();
            step();
        end
    endtask

    task automatic run_to(input int th, input int tv, input string tag);
        int k;
        k = 0;
        while (!(gh == th && gv == tv) && k < 2000) begin
            drive_clean();
            step();
            k++;
        end
        chk(tag, 32'(k < 2000), 32'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_fs"}, 32'(frame_start), 32'd0);
        chk({tag, "_ep"}, 32'(err_pulse), 32'd0);
        chk({tag, "_flags"}, 32'(err_flags), 32'd0);
        chk({tag, "_cnt"}, 32'(err_count), 32'd0);
        chk({tag, "_fc"}, 32'(frame_count), 32'd0);
    endtask

    task automatic relock(input string tag);
        run_to(0, 0, tag);
        run(3);
        exp_fc++;
    endtask

    initial begin
        rst_n   = 1'b0;
        clr_err = 1'b0;
        drive_clean();

        // Reset
        run(3);
        chk_zero("reset");
        rst_n = 1'b1;

        // Clean frames from reset
        run_to(0, 0, "t1_runto");
        run(1);
        chk("t1_locked_early", 32'(locked), 32'd0);
        run(1);
        chk("t1_locked_2clk", 32'(locked), 32'd1);
        chk("t1_fc_first", 32'(frame_count), 32'd1);
        run(1599);
        run(2);
        exp_fc = 3;
        chk("t1_fc", 32'(frame_count), 32'd3);
        chk("t1_fs_pulses", 32'(n_fs), 32'd3);
        chk("t1_cnt", 32'(err_count), 32'd0);
        chk("t1_flags", 32'(err_flags), 32'd0);
        chk("t1_ep", 32'(n_ep), 32'd0);
        chk("t1_locked", 32'(locked), 32'd1);

        // hcount 6 where 5 expected
        run_to(5, 3, "t2_runto");
        ep0 = n_ep;
        drive_clean();
        vga.hcount = 11'd6;
        step();
        run(2);
        chk("t2_ep", 32'(n_ep - ep0), 32'd1);
        chk("t2_flags", 32'(err_flags), 32'h01);
        chk("t2_cnt", 32'(err_count), 32'd1);
        chk("t2_locked", 32'(locked), 32'd0);
        relock("t2_relock");
        chk("t2_relocked", 32'(locked), 32'd1);
        chk("t2_fc", 32'(frame_count), 32'(exp_fc));

        // hsync dropped inside the sync window
        run_to(33, 2, "t3_runto");
        drive_clean();
        vga.hsync = 1'b0;
        step();
        run(2);
`ifdef VGA_MON_SYNC_CHECK_EN
        chk("t3_flags", 32'(err_flags), 32'h05);
        chk("t3_cnt", 32'(err_count), 32'd2);
        chk("t3_locked", 32'(locked), 32'd0);
`else
        chk("t3_flags", 32'(err_flags), 32'h01);
        chk("t3_cnt", 32'(err_count), 32'd1);
        chk("t3_locked", 32'(locked), 32'd1);
`endif
        relock("t3_relock");
        chk("t3_fc", 32'(frame_count), 32'(exp_fc));

        // clr_err alone
        drive_clean();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        run(1);
        chk("clr1_flags", 32'(err_flags), 32'd0);
        chk("clr1_cnt", 32'(err_count), 32'd0);
        chk("clr1_locked", 32'(locked), 32'd1);

        // vcount 10 -> 12 with wrong vblnk
        run_to(39, 10, "t4_runto");
        run(1);
        ep0 = n_ep;
        drive_clean();
        vga.vcount = 11'd12;
        vga.vblnk  = 1'b1;
        step();
        run(2);
`ifdef VGA_MON_SYNC_CHECK_EN
        chk("t4_flags", 32'(err_flags), 32'h22);
`else
        chk("t4_flags", 32'(err_flags), 32'h02);
`endif
        chk("t4_cnt", 32'(err_count), 32'd1);
        chk("t4_ep", 32'(n_ep - ep0), 32'd1);
        chk("t4_locked", 32'(locked), 32'd0);
        relock("t4_relock");

        // clr_err in the same cycle as a new error
        run_to(10, 4, "t5_runto");
        drive_clean();
`ifdef VGA_MON_SYNC_CHECK_EN
        vga.hblnk = 1'b1;
`else
        vga.hcount = 11'd11;
`endif
        step();
        drive_clean();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        run(1);
`ifdef VGA_MON_SYNC_CHECK_EN
        chk("t5_flags", 32'(err_flags), 32'h08);
`else
        chk("t5_flags", 32'(err_flags), 32'h01);
`endif
        chk("t5_cnt", 32'(err_count), 32'd1);
        chk("t5_locked", 32'(locked), 32'd0);
        drive_clean();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("clr2_flags", 32'(err_flags), 32'd0);
        chk("clr2_cnt", 32'(err_count), 32'd0);
        chk("clr2_fc", 32'(frame_count), 32'(exp_fc));

        // 300 errors: lock on 0,0 then break the sequence immediately
        ep0 = n_ep;
        fs0 = n_fs;
        for (int i = 0; i < 300; i++) begin
            gh = 0;
            gv = 0;
            run(1);
            gh = 5;
            gv = 0;
            run(1);
        end
        run(2);
        exp_fc += 300;
        chk("t6_cnt_sat", 32'(err_count), 32'd255);
        chk("t6_flags", 32'(err_flags), 32'h01);
        chk("t6_ep", 32'(n_ep - ep0), 32'd300);
        chk("t6_fs", 32'(n_fs - fs0), 32'd300);
        chk("t6_fc", 32'(frame_count), 32'(exp_fc));
        chk("t6_locked", 32'(locked), 32'd0);

        // Reset mid-lock
        gh = 0;
        gv = 0;
        run(3);
        exp_fc++;
        chk("t7_locked", 32'(locked), 32'd1);
        chk("t7_fc", 32'(frame_count), 32'(exp_fc));
        run(50);
        rst_n = 1'b0;
        run(1);
        chk_zero("t7_rst");
        rst_n = 1'b1;
        run(2);
        chk("t7_postrst_locked", 32'(locked), 32'd0);
        run_to(0, 0, "t7_runto");
        run(3);
        chk("t7_relocked", 32'(locked), 32'd1);
        chk("t7_fc_after", 32'(frame_count), 32'd1);
        chk("t7_cnt_after", 32'(err_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
